// File: rtl/mem_array_ctrl_if.sv
// Bus interface for mem_array_ctrl.
// The parity pins (par_inject, parity_err) exist only when PARITY_EN is defined.
interface mem_array_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  // Strobe semantics: there is no ready signal.
  // - read, write and clear are sampled on every rising clock edge.
  // - While busy=1, any strobe is dropped rather than stalled.
  // - rd_valid pulses high for exactly one cycle; data_out is updated in that cycle.
  logic              read;
  logic              write;
  logic              clear;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              busy;
`ifdef PARITY_EN
  logic              par_inject;
  logic              parity_err;

  modport master (
    output read, write, clear, addr, data_in, par_inject,
    input  data_out, rd_valid, busy, parity_err
  );
  modport slave (
    input  read, write, clear, addr, data_in, par_inject,
    output data_out, rd_valid, busy, parity_err
  );
`else
  modport master (
    output read, write, clear, addr, data_in,
    input  data_out, rd_valid, busy
  );
  modport slave (
    input  read, write, clear, addr, data_in,
    output data_out, rd_valid, busy
  );
`endif
endinterface

// File: rtl/mem_array_ctrl.sv
// Single-port memory with a registered read port and a hardware clear engine.
// Optional feature macro: PARITY_EN (adds one even-parity bit per stored word).
module mem_array_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input logic            clk,
  input logic            rst_n,
  mem_array_ctrl_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
`ifdef PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              rd_valid_q, rd_valid_d;
`ifdef PARITY_EN
  logic              parity_err_q, parity_err_d;
`endif

  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [MEM_W-1:0]  mem_wd;
  logic [MEM_W-1:0]  mem_rd;
  logic [MEM_W-1:0]  wr_word;
  logic [MEM_W-1:0]  mem [DEPTH];

  // The array is read combinationally here and registered below.
  // Because of that, a same-cycle write is never seen (read-before-write).
  assign mem_rd = mem[bus.addr];

`ifdef PARITY_EN
  assign wr_word = {(^bus.data_in) ^ bus.par_inject, bus.data_in};
`else
  assign wr_word = bus.data_in;
`endif

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    data_out_d = data_out_q;
    rd_valid_d = 1'b0;
    mem_we     = 1'b0;
    mem_wa     = bus.addr;
    mem_wd     = wr_word;
`ifdef PARITY_EN
    parity_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.clear) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end else begin
          if (bus.write) begin
            mem_we = 1'b1;
          end
          if (bus.read) begin
            data_out_d = mem_rd[DATA_W-1:0];
            rd_valid_d = 1'b1;
`ifdef PARITY_EN
            parity_err_d = ^mem_rd;
`endif
          end
        end
      end
      CLEAR: begin
        // A zero word with a zero parity bit is a correctly encoded word.
        mem_we    = 1'b1;
        mem_wa    = clr_cnt_q;
        mem_wd    = '0;
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      clr_cnt_q  <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
`ifdef PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
`ifdef PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Storage is deliberately left out of reset so that contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.busy     = (state_q == CLEAR);
`ifdef PARITY_EN
  assign bus.parity_err = parity_err_q;
`endif
endmodule
